// File: rtl/fixed_packer_pkg.sv
// Shared types and constants for the Q2.30 fixed-point to IEEE-754 single packer.
package packer_pkg;

  localparam int FP_BIAS           = 127;
  localparam int FP_EXP_W          = 8;
  localparam int FP_MAN_W          = 23;
  localparam int FRAC_BITS_DEFAULT = 30;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } pk_state_t;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  // The most negative input maps onto itself, which is exactly 2^31 as an unsigned magnitude.
  function automatic logic [31:0] abs_fixed(input logic [31:0] v);
    return v[31] ? ((~v) + 32'd1) : v;
  endfunction

endpackage

// File: rtl/fixed_packer_lzc32.sv
// Combinational leading-zero counter for a 32-bit word; an all-zero word reports 32.
module lzc32 (
  input  logic [31:0] in_word,
  output logic [5:0]  lz_count
);

  // Scanning upward lets the highest set bit overwrite any lower ones.
  always_comb begin
    lz_count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (in_word[i]) begin
        lz_count = 6'(31 - i);
      end
    end
  end

endmodule

// File: rtl/fixed_packer.sv
// Signed Q2.30 to IEEE-754 single converter with round-to-nearest-even.
// Define FIXED_PACKER_FAST_NORM_EN for a single-cycle leading-zero normaliser.
module fixed_packer
  import packer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_fixed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_float,
  output logic              busy
);

  localparam int SHIFT_W   = $clog2(DATA_W);
  localparam int LSB_POS   = DATA_W - 1 - FP_MAN_W;
  localparam int GUARD_POS = LSB_POS - 1;
  localparam int EXP_BASE  = FP_BIAS + DATA_W - 1 - FRAC_BITS;

  localparam logic [FP_EXP_W-1:0] EXP_BASE_V = EXP_BASE[FP_EXP_W-1:0];
  localparam logic [SHIFT_W-1:0]  SHIFT_ONE  = {{(SHIFT_W-1){1'b0}}, 1'b1};

  pk_state_t          state_q, state_d;
  logic               sign_q, sign_d;
  logic [DATA_W-1:0]  mag_q, mag_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  fp32_t              out_float_q, out_float_d;

  logic               round_lsb;
  logic               round_guard;
  logic               round_sticky;
  logic               round_up;
  logic [FP_MAN_W:0]  man_sum;
  logic [FP_EXP_W-1:0] exp_pre;
  fp32_t              rounded;

`ifdef FIXED_PACKER_FAST_NORM_EN
  logic [5:0] lz_count;
  logic       lz_unused;

  lzc32 u_lzc (
    .in_word  (mag_q),
    .lz_count (lz_count)
  );

  // The magnitude is never zero in NORM, so the count never reaches 32.
  assign lz_unused = lz_count[5];
`endif

  // Exponent range is 97..129, so 8-bit arithmetic cannot wrap here.
  always_comb begin
    round_lsb    = mag_q[LSB_POS];
    round_guard  = mag_q[GUARD_POS];
    round_sticky = |mag_q[GUARD_POS-1:0];
    round_up     = round_guard & (round_sticky | round_lsb);
    man_sum      = {1'b0, mag_q[DATA_W-2:LSB_POS]} + {{FP_MAN_W{1'b0}}, round_up};
    exp_pre      = EXP_BASE_V - {{(FP_EXP_W-SHIFT_W){1'b0}}, shift_q};
    rounded.sign = sign_q;
    rounded.exp  = exp_pre + {{(FP_EXP_W-1){1'b0}}, man_sum[FP_MAN_W]};
    rounded.man  = man_sum[FP_MAN_W] ? '0 : man_sum[FP_MAN_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    shift_d     = shift_q;
    out_float_d = out_float_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d  = in_fixed[DATA_W-1];
          mag_d   = abs_fixed(in_fixed);
          shift_d = '0;
          if (in_fixed == '0) begin
            out_float_d = '0;
            state_d     = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
`ifdef FIXED_PACKER_FAST_NORM_EN
        mag_d   = mag_q << lz_count[SHIFT_W-1:0];
        shift_d = lz_count[SHIFT_W-1:0];
        state_d = ROUND;
`else
        if (mag_q[DATA_W-1]) begin
          state_d = ROUND;
        end else begin
          mag_d   = mag_q << 1;
          shift_d = shift_q + SHIFT_ONE;
        end
`endif
      end
      ROUND: begin
        out_float_d = rounded;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      shift_q     <= '0;
      out_float_q <= '0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      shift_q     <= shift_d;
      out_float_q <= out_float_d;
    end
  end

  // Gating with rst_n keeps in_ready low while reset is held even though the state is already IDLE.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_float = out_float_q;

endmodule

// File: tb/tb_fixed_packer.sv
// Self-checking bench for fixed_packer: directed test-plan vectors, randomized values
// against an arithmetic rounding model, backpressure and mid-conversion reset.
module tb_fixed_packer;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_fixed  = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [31:0] out_float;

  int pass_count  = 0;
  int check_count = 0;

  localparam logic [31:0] DIR_IN  [10] = '{32'h40000000, 32'h26DD3B6A, 32'hC0000000, 32'h80000000,
                                           32'h00000000, 32'h00000001, 32'h7FFFFFFF, 32'h40000040,
                                           32'h400000C0, 32'h01000080};
  localparam logic [31:0] DIR_EXP [10] = '{32'h3F800000, 32'h3F1B74EE, 32'hBF800000, 32'hC0000000,
                                           32'h00000000, 32'h30800000, 32'h40000000, 32'h3F800000,
                                           32'h3F800002, 32'h3C800040};
  localparam int          DIR_LAT [10] = '{4, 5, 4, 3, 1, 34, 4, 4, 4, 10};

  always #5 clk = ~clk;

  fixed_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fixed  (in_fixed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_float (out_float),
    .busy      (busy)
  );

  // Value = x / 2^30; find the leading one, then round the 24-bit significand to nearest-even
  // by comparing the discarded remainder against half an ulp.
  function automatic logic [31:0] ref_float(input logic [31:0] x);
    logic        sgn;
    logic [63:0] m, q, rem, half;
    int          p, e;
    if (x == 32'h0) return 32'h0;
    sgn = x[31];
    m   = sgn ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
    p   = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    e = p - 30 + 127;
    if (p > 23) begin
      q    = m >> (p - 23);
      rem  = m - (q << (p - 23));
      half = 64'd1 << (p - 24);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    end else begin
      q = m << (23 - p);
    end
    if (q == 64'h100_0000) begin
      q = q >> 1;
      e = e + 1;
    end
    return {sgn, e[7:0], q[22:0]};
  endfunction

  function automatic int ref_latency(input logic [31:0] x);
    if (x == 32'h0) return 1;
`ifdef FIXED_PACKER_FAST_NORM_EN
    return 3;
`else
    begin
      logic [31:0] m;
      int          p;
      m = x[31] ? (32'd0 - x) : x;
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      return (31 - p) + 3;
    end
`endif
  endfunction

  // Latency counts the accept edge as 1; a refused accept reports -1.
  task automatic run_conv(input logic [31:0] val, input bit consume,
                          output logic [31:0] res, output int lat);
    int wait_cnt;
    @(negedge clk);
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!in_ready) begin
      lat = -1;
      res = 'x;
      return;
    end
    in_valid = 1'b1;
    in_fixed = val;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_fixed = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = out_float;
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    check_count++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
    else pass_count++;
    check_count++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else pass_count++;
    check_count++;
    if (out_float !== 32'h0) $display("[TB] FAIL reset_out_float: got %h expected 00000000", out_float);
    else pass_count++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_count++;
    if (in_ready !== 1'b1) $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready);
    else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL release_busy: got %b expected 0", busy);
    else pass_count++;
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int          lat, exp_lat;
    for (int i = 0; i < 10; i++) begin
      run_conv(DIR_IN[i], 1'b1, res, lat);
`ifdef FIXED_PACKER_FAST_NORM_EN
      exp_lat = (DIR_IN[i] == 32'h0) ? 1 : 3;
`else
      exp_lat = DIR_LAT[i];
`endif
      check_count++;
      if (res !== DIR_EXP[i])
        $display("[TB] FAIL directed_result in=%h: got %h expected %h", DIR_IN[i], res, DIR_EXP[i]);
      else pass_count++;
      check_count++;
      if (lat != exp_lat)
        $display("[TB] FAIL directed_latency in=%h: got %0d expected %0d", DIR_IN[i], lat, exp_lat);
      else pass_count++;
    end
  endtask

  task automatic test_random();
    logic [31:0] v, res, exp_res;
    int          lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      run_conv(v, 1'b1, res, lat);
      exp_res = ref_float(v);
      exp_lat = ref_latency(v);
      check_count++;
      if (res !== exp_res) $display("[TB] FAIL random_result in=%h: got %h expected %h", v, res, exp_res);
      else pass_count++;
      check_count++;
      if (lat != exp_lat) $display("[TB] FAIL random_latency in=%h: got %0d expected %0d", v, lat, exp_lat);
      else pass_count++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int          lat;
    run_conv(32'h26DD3B6A, 1'b0, res, lat);
    check_count++;
    if (res !== 32'h3F1B74EE) $display("[TB] FAIL bp_result: got %h expected 3F1B74EE", res);
    else pass_count++;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_fixed = 32'h40000000;
      @(negedge clk);
      check_count++;
      if (out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid cyc=%0d: got %b expected 1", c, out_valid);
      else pass_count++;
      check_count++;
      if (out_float !== 32'h3F1B74EE)
        $display("[TB] FAIL bp_out_float cyc=%0d: got %h expected 3F1B74EE", c, out_float);
      else pass_count++;
      check_count++;
      if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready cyc=%0d: got %b expected 0", c, in_ready);
      else pass_count++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_count++;
    if (out_valid !== 1'b0) $display("[TB] FAIL bp_release_out_valid: got %b expected 0", out_valid);
    else pass_count++;
    check_count++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_release_in_ready: got %b expected 1", in_ready);
    else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL bp_release_busy: got %b expected 0", busy);
    else pass_count++;
    @(negedge clk);
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL bp_ignored_input: got busy=%b expected 0", busy);
    else pass_count++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_fixed = 32'h00000001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_count++;
    if (busy !== 1'b1) $display("[TB] FAIL mid_busy_before: got %b expected 1", busy);
    else pass_count++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_count++;
    if (out_valid !== 1'b0) $display("[TB] FAIL mid_out_valid: got %b expected 0", out_valid);
    else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL mid_busy: got %b expected 0", busy);
    else pass_count++;
    check_count++;
    if (in_ready !== 1'b0) $display("[TB] FAIL mid_in_ready: got %b expected 0", in_ready);
    else pass_count++;
    check_count++;
    if (out_float !== 32'h0) $display("[TB] FAIL mid_out_float: got %h expected 00000000", out_float);
    else pass_count++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_count++;
    if (in_ready !== 1'b1) $display("[TB] FAIL mid_release_in_ready: got %b expected 1", in_ready);
    else pass_count++;
    run_conv(32'h40000000, 1'b1, res, lat);
    check_count++;
    if (res !== 32'h3F800000) $display("[TB] FAIL mid_next_result: got %h expected 3F800000", res);
    else pass_count++;
    check_count++;
    if (lat != ref_latency(32'h40000000))
      $display("[TB] FAIL mid_next_latency: got %0d expected %0d", lat, ref_latency(32'h40000000));
    else pass_count++;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
